tipi_rpi_master: RTL and testbench

TIPI_RPI_MASTER -- requirements
Module: tipi_rpi_master

---
 rtl/tipi_rpi_master.sv | 136 +++++++++++++
 tb/tb_tipi_rpi_master.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tipi_rpi_master.sv
// Serial master for the TIPI CPLD link: one byte per transaction, read or write,
// with every timed phase lasting CLK_DIV clocks.
module tipi_rpi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [0:1] op,
    input  logic [0:7] wdata,
    output logic [0:7] rdata,
    output logic       busy,
    output logic       done,
    output logic       r_clk,
    output logic       r_le,
    output logic       r_dc,
    output logic       r_rt,
    output logic       r_dout,
    input  logic       r_din
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] SETUP   = 4'd1;
    localparam logic [3:0] LOAD_HI = 4'd2;
    localparam logic [3:0] LOAD_LO = 4'd3;
    localparam logic [3:0] BIT_LO  = 4'd4;
    localparam logic [3:0] BIT_HI  = 4'd5;
    localparam logic [3:0] XFER_HI = 4'd6;
    localparam logic [3:0] XFER_LO = 4'd7;
    localparam logic [3:0] DONE    = 4'd8;

    localparam logic [7:0] PH_LAST = 8'(CLK_DIV - 1);

    logic [3:0] state_q, state_d;
    logic [7:0] phase_q, phase_d;
    logic [2:0] bit_q, bit_d;
    logic       rt_q, rt_d;
    logic       dc_q, dc_d;
    logic [0:7] wdata_q, wdata_d;
    logic [0:7] rx_q, rx_d;
    logic [0:7] rdata_q, rdata_d;
    logic       phase_end;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        rt_d      = rt_q;
        dc_d      = dc_q;
        wdata_d   = wdata_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        phase_end = (phase_q == PH_LAST);

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = SETUP;
                    rt_d    = op[0];
                    dc_d    = op[1];
                    wdata_d = wdata;
                    rx_d    = '0;
                    phase_d = '0;
                    bit_d   = '0;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                phase_d = phase_end ? '0 : phase_q + 8'd1;
                if (state_q == BIT_LO && rt_q && phase_end)
                    rx_d[bit_q] = r_din;
                if (phase_end) begin
                    case (state_q)
                        SETUP:   state_d = rt_q ? LOAD_HI : BIT_LO;
                        LOAD_HI: state_d = LOAD_LO;
                        LOAD_LO: state_d = BIT_LO;
                        BIT_LO:  state_d = BIT_HI;
                        BIT_HI: begin
                            if (bit_q == 3'd7) begin
                                bit_d = '0;
                                // Read data is published only once all eight bits are in,
                                // so an aborted read never leaks a partial byte.
                                if (rt_q) begin
                                    state_d = DONE;
                                    rdata_d = rx_q;
                                end else begin
                                    state_d = XFER_HI;
                                end
                            end else begin
                                bit_d   = bit_q + 3'd1;
                                state_d = BIT_LO;
                            end
                        end
                        XFER_HI: state_d = XFER_LO;
                        XFER_LO: state_d = DONE;
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            rt_q    <= 1'b0;
            dc_q    <= 1'b0;
            wdata_q <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            rt_q    <= rt_d;
            dc_q    <= dc_d;
            wdata_q <= wdata_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        busy   = (state_q != IDLE) && (state_q != DONE);
        done   = (state_q == DONE);
        r_clk  = (state_q == BIT_HI);
        r_le   = (state_q == LOAD_HI) || (state_q == XFER_HI);
        r_dout = !rt_q && ((state_q == BIT_LO) || (state_q == BIT_HI)) && wdata_q[bit_q];
        r_rt   = rt_q;
        r_dc   = dc_q;
        rdata  = rdata_q;
    end

endmodule

// File: tb/tb_tipi_rpi_master.sv
// Bench for tipi_rpi_master: waveform expectations derived from phase arithmetic
// plus a behavioural CPLD shift-register model.
module tb_tipi_rpi_master;

    localparam int D  = 4;
    localparam int PH = 19 * D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       req, req1;
    logic [0:1] op, op1;
    logic [0:7] wdata, wdata1;
    logic [0:7] rdata, rdata1;
    logic       busy, done, r_clk, r_le, r_dc, r_rt, r_dout, r_din;
    logic       busy1, done1, r_clk1, r_le1, r_dc1, r_rt1, r_dout1, r_din1;

    tipi_rpi_master #(.CLK_DIV(D)) u_dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done),
        .r_clk(r_clk), .r_le(r_le), .r_dc(r_dc), .r_rt(r_rt), .r_dout(r_dout),
        .r_din(r_din)
    );

    tipi_rpi_master #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .op(op1), .wdata(wdata1),
        .rdata(rdata1), .busy(busy1), .done(done1),
        .r_clk(r_clk1), .r_le(r_le1), .r_dc(r_dc1), .r_rt(r_rt1), .r_dout(r_dout1),
        .r_din(r_din1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [0:7] exp_rdata;
    logic [0:7] cpld_sr;
    logic [0:7] rx_byte;
    logic [0:7] latched;
    int         n_rise, n_le;
    logic       prev_clk, prev_le, prev_dout;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_reset_state();
        exp_rdata = '0;
        check("rst_rdata", 32'(rdata), 32'(exp_rdata));
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_r_clk", 32'(r_clk), 0);
        check("rst_r_le", 32'(r_le), 0);
        check("rst_r_dc", 32'(r_dc), 0);
        check("rst_r_rt", 32'(r_rt), 0);
        check("rst_r_dout", 32'(r_dout), 0);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            req = 1'b0;
            check("idle_busy", 32'(busy), 0);
            check("idle_done", 32'(done), 0);
        end
    endtask

    // Caller is at a negedge with the DUT in IDLE; acceptance happens on the next edge.
    task automatic run_txn(input logic [0:1] o, input logic [0:7] wd, input logic [0:7] cv,
                           input int pulse_k, input int abort_k);
        int   p, i;
        logic is_done, e_le, e_clk, e_dout;
        req = 1'b1; op = o; wdata = wd;
        cpld_sr = '0; rx_byte = '0; latched = '0;
        n_rise = 0; n_le = 0;
        prev_clk = 1'b0; prev_le = 1'b0; prev_dout = 1'b0;
        for (int k = 1; k <= PH + 1; k++) begin
            @(negedge clk);
            req = (k == pulse_k);
            if (k == abort_k) begin
                reset = 1'b1;
                #1;
                check_reset_state();
                @(negedge clk);
                check_reset_state();
                return;
            end
            // CPLD: shift on r_clk rise, parallel-load / latch on r_le
            if (r_clk && !prev_clk) begin
                if (o[0]) cpld_sr = {cpld_sr[1:7], 1'b0};
                else if (n_rise < 8) rx_byte[n_rise] = r_dout;
                n_rise++;
            end
            if (r_le && !prev_le) n_le++;
            if (r_le && o[0]) cpld_sr = cv;
            if (r_le && !o[0]) latched = rx_byte;
            r_din = cpld_sr[0];

            check("le_clk_excl", 32'(r_le && r_clk), 0);
            if (r_clk && prev_clk) check("dout_stable_hi", 32'(r_dout), 32'(prev_dout));

            p = (k - 1) / D;
            is_done = (k == PH + 1);
            e_le = 1'b0; e_clk = 1'b0; e_dout = 1'b0;
            if (!is_done) begin
                if (o[0]) begin
                    e_le  = (p == 1);
                    e_clk = (p >= 3) && (((p - 3) % 2) == 1);
                end else begin
                    if (p >= 1 && p <= 16) begin
                        i      = (p - 1) / 2;
                        e_clk  = (((p - 1) % 2) == 1);
                        e_dout = wd[i];
                    end
                    e_le = (p == 17);
                end
            end
            if (is_done && o[0]) exp_rdata = cv;

            check("busy", 32'(busy), 32'(!is_done));
            check("done", 32'(done), 32'(is_done));
            check("r_clk", 32'(r_clk), 32'(e_clk));
            check("r_le", 32'(r_le), 32'(e_le));
            check("r_dout", 32'(r_dout), 32'(e_dout));
            check("r_rt", 32'(r_rt), 32'(o[0]));
            check("r_dc", 32'(r_dc), 32'(o[1]));
            check("rdata", 32'(rdata), 32'(exp_rdata));

            prev_clk = r_clk; prev_le = r_le; prev_dout = r_dout;
        end
        check("clk_rises", 32'(n_rise), 8);
        check("le_pulses", 32'(n_le), 1);
        if (!o[0]) check("cpld_rx", 32'(latched), 32'(wd));
    endtask

    initial begin
        logic [0:15] bits1;
        int          nb;
        logic        pc;
        logic [0:7]  b_hi, b_lo;

        reset = 1'b1; req = 1'b0; req1 = 1'b0;
        op = '0; op1 = '0; wdata = '0; wdata1 = '0;
        r_din = 1'b0; r_din1 = 1'b0;
        exp_rdata = '0;
        repeat (2) @(negedge clk);
        check_reset_state();
        check("rst1_busy", 32'(busy1), 0);
        check("rst1_rdata", 32'(rdata1), 0);

        // First accept on the very first cycle out of reset
        reset = 1'b0;
        run_txn(2'b00, 8'hA5, 8'h00, 0, 0);
        idle(1);
        run_txn(2'b10, 8'h00, 8'h3C, 0, 0);
        idle(1);
        // Request pulse mid-read must be ignored
        run_txn(2'b10, 8'h11, 8'h96, 10, 0);
        idle(3);
        // Abort at the start of the 5th BIT_HI of a write
        run_txn(2'b00, 8'hC3, 8'h00, 0, 10 * D + 1);
        reset = 1'b0;
        run_txn(2'b10, 8'h00, 8'h5A, 0, 0);
        idle(1);

        // CLK_DIV=1 back-to-back writes with req held high
        req1 = 1'b1; op1 = 2'b01; wdata1 = 8'hFF;
        bits1 = '0; nb = 0; pc = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1) wdata1 = 8'h00;
            if (k == 41) req1 = 1'b0;
            if (r_clk1 && !pc && nb < 16) begin
                bits1[nb] = r_dout1;
                nb++;
            end
            pc = r_clk1;
            check("d1_le_clk", 32'(r_le1 && r_clk1), 0);
            check("d1_done", 32'(done1), 32'(k == 20 || k == 41));
            check("d1_busy", 32'(busy1), 32'(k <= 19 || (k >= 22 && k <= 40)));
            if (k == 10) begin
                check("d1_r_rt", 32'(r_rt1), 0);
                check("d1_r_dc", 32'(r_dc1), 1);
            end
        end
        b_hi = bits1[0:7];
        b_lo = bits1[8:15];
        check("d1_rises", 32'(nb), 16);
        check("d1_byte0", 32'(b_hi), 32'h0000_00FF);
        check("d1_byte1", 32'(b_lo), 0);
        check("d1_rdata", 32'(rdata1), 0);

        for (int n = 0; n < 12; n++) begin
            run_txn(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 0, 0);
            idle($urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
